// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared 32-bit bus, with one dead cycle between owners.
// Define BUS_ARB_TIMEOUT_EN to force release of an owner after MAX_HOLD consecutive grant cycles.
module bus_arbiter #(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  if (MAX_HOLD < 1 || (1 << SEL_W) < NUM_SRC) begin : g_bad_cfg
    $error("bus_arbiter: MAX_HOLD must be >= 1 and 2**SEL_W >= NUM_SRC");
  end

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 found;
  logic [SEL_W-1:0]     win, cand;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    found = 1'b0;
    win   = '0;
    cand  = '0;

    // Search starts just past the last owner, so it ranks lowest next round.
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = SEL_W'((int'(ptr_q) + i) % NUM_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          ptr_d   = win;
          gnt_d   = NUM_SRC'(1) << win;
          sel_d   = win;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[ptr_q]) begin
          state_d = GAP;
          gnt_d   = '0;
          sel_d   = '0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          gnt_d     = '0;
          sel_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; clear is synchronous, so it is only seen at an edge.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(NUM_SRC - 1);
      gnt_q   <= '0;
      sel_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = |gnt_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed steps push per-cycle expectations, a negedge monitor compares them.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] req   = '0;
  logic [23:0] gnt;
  logic [4:0]  sel;
  logic        busy;
  logic        timeout;

  bus_arbiter dut (
    .clock  (clock),
    .clear  (clear),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int    cyc;
    int    idx;
    logic  to;
    string name;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] prev_gnt = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle of inputs and records what must be visible after the sampling edge.
  task automatic step(input logic c, input logic [23:0] r, input int idx, input logic to, input string name);
    exp_t e;
    clear  = c;
    req    = r;
    e.cyc  = cyc + 1;
    e.idx  = idx;
    e.to   = to;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  // Monitor: scoreboard pops plus bus invariants, sampled away from the active edge.
  always @(negedge clock) begin
    if (cyc >= 2) begin
      int          exp_sel;
      logic [23:0] exp_gnt;
      exp_sel = 0;
      for (int i = 0; i < 24; i++) if (gnt[i]) exp_sel = i;
      check("inv_onehot", 32'((gnt & (gnt - 24'd1)) == 24'd0), 32'd1);
      check("inv_sel", 32'(sel), 32'(exp_sel));
      check("inv_busy", 32'(busy), 32'(|gnt));
      check("inv_no_switch", 32'(!(prev_gnt != 0 && gnt != 0 && gnt != prev_gnt)), 32'd1);
      prev_gnt = gnt;

      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.name, e.cyc, cyc);
        end else begin
          exp_gnt = (e.idx < 0) ? 24'd0 : (24'd1 << e.idx);
          check({e.name, "_gnt"}, 32'(gnt), 32'(exp_gnt));
          check({e.name, "_sel"}, 32'(sel), (e.idx < 0) ? 32'd0 : 32'(e.idx));
          check({e.name, "_busy"}, 32'(busy), 32'(e.idx >= 0));
          check({e.name, "_timeout"}, 32'(timeout), 32'(e.to));
        end
      end
    end
  end

  localparam logic [23:0] RR = 24'h800021;

  initial begin
    @(posedge clock);
    #2;
    // Reset with every source requesting, then release.
    step(1'b0, 24'hFFFFFF, -1, 1'b0, "reset0");
    step(1'b0, 24'hFFFFFF, -1, 1'b0, "reset1");
    step(1'b1, 24'hFFFFFF,  0, 1'b0, "first_gnt");
    step(1'b1, 24'hFFFFFF,  0, 1'b0, "first_hold");
    step(1'b0, 24'hFFFFFF, -1, 1'b0, "reset_mid_grant");
    step(1'b1, 24'h000000, -1, 1'b0, "idle_after_reset");

    // Single requester held three cycles.
    repeat (3) step(1'b1, 24'h000004, 2, 1'b0, "single");
    step(1'b1, 24'h000000, -1, 1'b0, "single_gap");
    step(1'b1, 24'h000000, -1, 1'b0, "single_idle0");
    step(1'b1, 24'h000000, -1, 1'b0, "single_idle1");

    // Round-robin over 0, 5, 23 from a fresh pointer.
    step(1'b0, 24'h000000, -1, 1'b0, "rr_reset");
    step(1'b1, RR,               0, 1'b0, "rr_g0");
    step(1'b1, RR & ~24'h000001, -1, 1'b0, "rr_gap0");
    step(1'b1, RR,              -1, 1'b0, "rr_idle0");
    step(1'b1, RR,               5, 1'b0, "rr_g5");
    step(1'b1, RR & ~24'h000020, -1, 1'b0, "rr_gap5");
    step(1'b1, RR,              -1, 1'b0, "rr_idle5");
    step(1'b1, RR,              23, 1'b0, "rr_g23");
    step(1'b1, RR & ~24'h800000, -1, 1'b0, "rr_gap23");
    step(1'b1, RR,              -1, 1'b0, "rr_idle23");
    step(1'b1, RR,               0, 1'b0, "rr_g0_again");
    step(1'b1, 24'h000000,      -1, 1'b0, "rr_gap_end");
    step(1'b1, 24'h000000,      -1, 1'b0, "rr_idle_end");

    // Wrap-around after granting the top source.
    step(1'b1, 24'h800000, 23, 1'b0, "wrap_g23");
    step(1'b1, 24'h400002, -1, 1'b0, "wrap_gap");
    step(1'b1, 24'h400002, -1, 1'b0, "wrap_idle");
    step(1'b1, 24'h400002,  1, 1'b0, "wrap_g1");
    step(1'b1, 24'h400000, -1, 1'b0, "wrap_gap1");
    step(1'b1, 24'h400000, -1, 1'b0, "wrap_idle1");
    step(1'b1, 24'h400000, 22, 1'b0, "wrap_g22");
    step(1'b1, 24'h000000, -1, 1'b0, "wrap_gap22");
    step(1'b1, 24'h000000, -1, 1'b0, "wrap_idle22");

    // Owner 3 drops on the same edge that 4 rises; then 4 re-raises during GAP alongside 2.
    step(1'b1, 24'h000008,  3, 1'b0, "sim_g3");
    step(1'b1, 24'h000008,  3, 1'b0, "sim_h3");
    step(1'b1, 24'h000010, -1, 1'b0, "sim_gap");
    step(1'b1, 24'h000010, -1, 1'b0, "sim_idle");
    step(1'b1, 24'h000010,  4, 1'b0, "sim_g4");
    step(1'b1, 24'h000000, -1, 1'b0, "regap");
    step(1'b1, 24'h000014, -1, 1'b0, "reraise_idle");
    step(1'b1, 24'h000014,  2, 1'b0, "reraise_g2");
    step(1'b1, 24'h000000, -1, 1'b0, "reraise_gap");
    step(1'b1, 24'h000000, -1, 1'b0, "reraise_idle2");

    // Sources 7 and 9 requesting continuously.
    for (int k = 0; k < 21; k++) begin
`ifdef BUS_ARB_TIMEOUT_EN
      int   idx;
      logic to;
      to = 1'b0;
      if (k < 8)        idx = 7;
      else if (k == 8)  begin idx = -1; to = 1'b1; end
      else if (k == 9)  idx = -1;
      else if (k < 18)  idx = 9;
      else if (k == 18) begin idx = -1; to = 1'b1; end
      else if (k == 19) idx = -1;
      else              idx = 7;
      step(1'b1, 24'h000280, idx, to, "hold");
`else
      step(1'b1, 24'h000280, 7, 1'b0, "hold");
`endif
    end
    step(1'b1, 24'h000000, -1, 1'b0, "hold_release");
    step(1'b1, 24'h000000, -1, 1'b0, "hold_idle");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
